// File: rtl/ws2812_pkg.sv
// Shared types and 200 MHz default timing for the WS2812/SK6812 serializer.
package ws2812_pkg;

  typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;

  localparam int unsigned CNT_T0H_DEF = 70;
  localparam int unsigned CNT_T1H_DEF = 180;
  localparam int unsigned CNT_BIT_DEF = 250;
  localparam int unsigned CNT_RST_DEF = 60000;

endpackage

// File: rtl/ws2812_bit_timer.sv
// Bit-period counter shared by all channels: end-of-bit strobe and high-time compares.
module ws2812_bit_timer #(
  parameter int unsigned CNT_T0H = 70,
  parameter int unsigned CNT_T1H = 180,
  parameter int unsigned CNT_BIT = 250
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic run,
  output logic bit_end,
  output logic hi0,
  output logic hi1
);

  localparam int unsigned CW = $clog2(CNT_BIT);
  localparam logic [CW-1:0] CntLast = CW'(CNT_BIT - 1);

  logic [CW-1:0] cyc_cnt_q, cyc_cnt_d;

  assign bit_end = run && (cyc_cnt_q == CntLast);

  always_comb begin
    cyc_cnt_d = cyc_cnt_q + CW'(1);
    if (!run || bit_end) cyc_cnt_d = '0;
  end

  // Compares look at the next count so the registered line lines up with it.
  assign hi0 = cyc_cnt_d < CW'(CNT_T0H);
  assign hi1 = cyc_cnt_d < CW'(CNT_T1H);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) cyc_cnt_q <= '0;
    else           cyc_cnt_q <= cyc_cnt_d;
  end

endmodule

// File: rtl/ws2812_tx.sv
// Multi-channel WS2812/SK6812 serializer: one pixel word per channel, shifted out
// MSB-first in lockstep, with a latch low period after the frame's last pixel.
module ws2812_tx
  import ws2812_pkg::*;
#(
  parameter int unsigned CH_NUM   = 4,
  parameter int unsigned PIX_BITS = 24,
  parameter int unsigned CNT_T0H  = CNT_T0H_DEF,
  parameter int unsigned CNT_T1H  = CNT_T1H_DEF,
  parameter int unsigned CNT_BIT  = CNT_BIT_DEF,
  parameter int unsigned CNT_RST  = CNT_RST_DEF
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       pix_valid_in,
  input  logic [CH_NUM*PIX_BITS-1:0] pix_data_in,
  input  logic                       pix_last_in,
  output logic                       pix_ready_out,
  output logic                       busy_out,
  output logic                       frame_done_out,
  output logic [CH_NUM-1:0]          ws2812_data_out
);

  if (!(CNT_T0H > 0 && CNT_T0H < CNT_T1H && CNT_T1H < CNT_BIT && CNT_RST >= 1 &&
        CH_NUM >= 1 && PIX_BITS >= 2)) begin : g_param_err
    $error("ws2812_tx: illegal parameter combination");
  end

  localparam int unsigned SW = CH_NUM * PIX_BITS;
  localparam int unsigned IW = $clog2(PIX_BITS);
  localparam int unsigned RW = (CNT_RST > 1) ? $clog2(CNT_RST) : 1;
  localparam logic [IW-1:0] IdxLast = IW'(PIX_BITS - 1);
  localparam logic [RW-1:0] RstLast = RW'(CNT_RST - 1);

  state_t            state_q, state_d;
  logic [IW-1:0]     bit_idx_q, bit_idx_d;
  logic [RW-1:0]     rst_cnt_q, rst_cnt_d;
  logic [SW-1:0]     shift_q, shift_d, shifted;
  logic              last_q, last_d;
  logic              done_q, done_d;
  logic [CH_NUM-1:0] line_q, line_d;
  logic              bit_end, hi0, hi1, pix_end, accept;

  ws2812_bit_timer #(
    .CNT_T0H (CNT_T0H),
    .CNT_T1H (CNT_T1H),
    .CNT_BIT (CNT_BIT)
  ) u_bit_timer (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .run      (state_q == SEND),
    .bit_end  (bit_end),
    .hi0      (hi0),
    .hi1      (hi1)
  );

  assign pix_end        = bit_end && (bit_idx_q == IdxLast);
  assign pix_ready_out  = (state_q == IDLE) || ((state_q == SEND) && pix_end && !last_q);
  assign accept         = pix_valid_in && pix_ready_out;
  assign busy_out       = (state_q != IDLE);
  assign frame_done_out = done_q;
  assign ws2812_data_out = line_q;

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    rst_cnt_d = rst_cnt_q;
    shift_d   = shift_q;
    last_d    = last_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) state_d = SEND;
      end
      SEND: begin
        // A non-last pixel without a successor underruns back to IDLE.
        if (pix_end) begin
          if (last_q)       state_d = LATCH;
          else if (!accept) state_d = IDLE;
        end
      end
      LATCH: begin
        if (rst_cnt_q == RstLast) begin
          state_d   = IDLE;
          rst_cnt_d = '0;
          done_d    = 1'b1;
        end else begin
          rst_cnt_d = rst_cnt_q + RW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      shift_d   = pix_data_in;
      last_d    = pix_last_in;
      bit_idx_d = '0;
    end else if (bit_end) begin
      shift_d   = shifted;
      bit_idx_d = pix_end ? '0 : bit_idx_q + IW'(1);
    end
  end

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    localparam int unsigned Lo = c * PIX_BITS;
    assign shifted[Lo +: PIX_BITS] = {shift_q[Lo +: PIX_BITS-1], 1'b0};
    assign line_d[c] = (state_d == SEND) && (shift_d[Lo+PIX_BITS-1] ? hi1 : hi0);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= IDLE;
      bit_idx_q <= '0;
      rst_cnt_q <= '0;
      shift_q   <= '0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      line_q    <= '0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      rst_cnt_q <= rst_cnt_d;
      shift_q   <= shift_d;
      last_q    <= last_d;
      done_q    <= done_d;
      line_q    <= line_d;
    end
  end

endmodule
